atm_db_arbiter: RTL and testbench

ATM_DB_ARBITER -- requirements
Module: atm_db_arbiter

---
 rtl/atm_db_arbiter.sv | 179 +++++++++++++++++
 tb/tb_atm_db_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_db_arbiter.sv
// atm_db_arbiter
//   Round-robin arbiter in front of a small account-balance register file.
//   Up to four ATM front-ends issue balance/withdraw/deposit transactions.
//   Each transaction passes IDLE (grant) -> EXEC (evaluate/update) ->
//   RESP (done pulse), so one transaction completes every 3 cycles.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   req[NUM_REQ]             per-requester level request, held until done
//   op_flat/acc_flat/amt_flat per-requester opcode (2b), account (4b), amount
//   init_we/init_idx/init_data preload write port, honoured only in IDLE
//   gnt[NUM_REQ]             one-hot grant, held through EXEC and RESP
//   done/done_id             completion pulse and requester it belongs to
//   success/balance          outcome and resulting balance, hold between dones
//   busy                     FSM is not IDLE
module atm_db_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_ACC = 10,
  parameter int BAL_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [2*NUM_REQ-1:0]     op_flat,
  input  logic [4*NUM_REQ-1:0]     acc_flat,
  input  logic [BAL_W*NUM_REQ-1:0] amt_flat,
  input  logic                     init_we,
  input  logic [3:0]               init_idx,
  input  logic [BAL_W-1:0]         init_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     done,
  output logic [1:0]               done_id,
  output logic                     success,
  output logic [BAL_W-1:0]         balance,
  output logic                     busy
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

  localparam logic [1:0] OP_BAL = 2'b00;
  localparam logic [1:0] OP_WD  = 2'b01;
  localparam logic [1:0] OP_DEP = 2'b10;

  typedef struct packed {
    logic [1:0]       op;
    logic [3:0]       acc;
    logic [BAL_W-1:0] amt;
  } txn_t;

  txn_t [NUM_REQ-1:0] txn_in;
  txn_t               cur;

  logic [1:0]       state;
  logic [1:0]       ptr;      // first requester searched at the next grant
  logic [BAL_W-1:0] mem [NUM_ACC];

  // per-requester unpack of the flat request buses
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign txn_in[g] = {op_flat[2*g +: 2], acc_flat[4*g +: 4], amt_flat[BAL_W*g +: BAL_W]};
  end

  // round-robin pick: first asserted req starting at ptr, wrapping
  logic       win_vld;
  logic [1:0] win_id;
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req[(int'(ptr) + i) % NUM_REQ]) begin
        win_vld = 1'b1;
        win_id  = 2'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  // evaluation of the latched transaction (used in EXEC)
  logic             acc_ok;
  logic [BAL_W-1:0] entry;
  logic [BAL_W:0]   sum;
  logic             nxt_ok;
  logic [BAL_W-1:0] nxt_bal;
  logic             wr_en;
  logic [BAL_W-1:0] wr_val;

  assign acc_ok = int'(cur.acc) < NUM_ACC;
  assign entry  = acc_ok ? mem[cur.acc] : '0;
  assign sum    = {1'b0, entry} + {1'b0, cur.amt};

  always_comb begin
    nxt_ok  = 1'b0;
    nxt_bal = '0;
    wr_en   = 1'b0;
    wr_val  = entry;
    if (acc_ok) begin
      case (cur.op)
        OP_BAL: begin
          nxt_ok  = 1'b1;
          nxt_bal = entry;
        end
        OP_WD: begin
          if (cur.amt <= entry) begin
            nxt_ok  = 1'b1;
            wr_en   = 1'b1;
            wr_val  = entry - cur.amt;
            nxt_bal = entry - cur.amt;
          end else begin
            nxt_bal = entry;
          end
        end
        OP_DEP: begin
          // carry out of the widened sum means the balance would wrap
          if (sum[BAL_W]) begin
            nxt_bal = entry;
          end else begin
            nxt_ok  = 1'b1;
            wr_en   = 1'b1;
            wr_val  = sum[BAL_W-1:0];
            nxt_bal = sum[BAL_W-1:0];
          end
        end
        default: begin
          nxt_ok  = 1'b0;
          nxt_bal = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      success <= 1'b0;
      balance <= '0;
      cur     <= '0;
      for (int a = 0; a < NUM_ACC; a++) mem[a] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // preload has priority over arbitration
          if (init_we) begin
            if (int'(init_idx) < NUM_ACC) mem[init_idx] <= init_data;
          end else if (win_vld) begin
            gnt         <= '0;
            gnt[win_id] <= 1'b1;
            cur         <= txn_in[win_id];
            done_id     <= win_id;
            ptr         <= 2'((int'(win_id) + 1) % NUM_REQ);
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (wr_en) mem[cur.acc] <= wr_val;
          success <= nxt_ok;
          balance <= nxt_bal;
          done    <= 1'b1;
          state   <= S_RESP;
        end
        S_RESP: begin
          gnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_atm_db_arbiter.sv
module tb_atm_db_arbiter;

  localparam int NUM_REQ = 4;
  localparam int NUM_ACC = 10;
  localparam int BAL_W   = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     op_flat;
  logic [4*NUM_REQ-1:0]     acc_flat;
  logic [BAL_W*NUM_REQ-1:0] amt_flat;
  logic                     init_we;
  logic [3:0]               init_idx;
  logic [BAL_W-1:0]         init_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     done;
  logic [1:0]               done_id;
  logic                     success;
  logic [BAL_W-1:0]         balance;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  atm_db_arbiter #(.NUM_REQ(NUM_REQ), .NUM_ACC(NUM_ACC), .BAL_W(BAL_W)) dut (
    .clk(clk), .rst(rst), .req(req), .op_flat(op_flat), .acc_flat(acc_flat),
    .amt_flat(amt_flat), .init_we(init_we), .init_idx(init_idx),
    .init_data(init_data), .gnt(gnt), .done(done), .done_id(done_id),
    .success(success), .balance(balance), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    init_we = 1'b1; init_idx = idx; init_data = data;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic set_txn(input int id, input logic [1:0] op, input logic [3:0] acc, input logic [31:0] amt);
    op_flat[2*id +: 2]   = op;
    acc_flat[4*id +: 4]  = acc;
    amt_flat[32*id +: 32] = amt;
  endtask

  // runs one transaction for a single requester and returns what done reported
  task automatic do_txn(input int id, input logic [1:0] op, input logic [3:0] acc, input logic [31:0] amt,
                        output logic s, output logic [31:0] b, output logic [1:0] did);
    bit seen;
    seen = 0; s = 1'bx; b = 'x; did = 'x;
    @(negedge clk);
    set_txn(id, op, acc, amt);
    req[id] = 1'b1;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1; s = success; b = balance; did = done_id;
      end
    end
    req[id] = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL txn_timeout req=%0d: no done within 12 cycles", id); end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; op_flat = '0; acc_flat = '0; amt_flat = '0;
    init_we = 1'b0; init_idx = '0; init_data = '0;
    #3;
    @(negedge clk);
    checks++;
    if ({gnt, done, done_id, success, balance, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b done=%b id=%0d succ=%b bal=%h busy=%b, all zero required",
               gnt, done, done_id, success, balance, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_withdraw;
    preload(4'd3, 32'd500);
    @(negedge clk);
    set_txn(1, 2'b01, 4'd3, 32'd200);
    req[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL wd_grant gnt=%b busy=%b done=%b, need 0010/1/0", gnt, busy, done);
    end
    req[1] = 1'b0;  // dropping req after grant must not abort
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || done_id !== 2'd1 || success !== 1'b1 || balance !== 32'd300 || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL wd_done done=%b id=%0d succ=%b bal=%0d gnt=%b, need 1/1/1/300/0010",
               done, done_id, success, balance, gnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || success !== 1'b1 || balance !== 32'd300) begin
      errors++;
      $display("FAIL wd_after done=%b gnt=%b busy=%b succ=%b bal=%0d, need 0/0000/0/1/300",
               done, gnt, busy, success, balance);
    end
  endtask

  task automatic test_insufficient;
    logic s; logic [31:0] b; logic [1:0] d;
    do_txn(1, 2'b01, 4'd3, 32'd301, s, b, d);
    checks++;
    if (s !== 1'b0 || b !== 32'd300) begin
      errors++; $display("FAIL wd_insufficient succ=%b bal=%0d, need 0/300", s, b);
    end
    do_txn(2, 2'b00, 4'd3, 32'd0, s, b, d);
    checks++;
    if (s !== 1'b1 || b !== 32'd300 || d !== 2'd2) begin
      errors++; $display("FAIL wd_insufficient_query succ=%b bal=%0d id=%0d, need 1/300/2", s, b, d);
    end
  endtask

  task automatic test_deposit_overflow;
    logic s; logic [31:0] b; logic [1:0] d;
    preload(4'd5, 32'hFFFF_FFF0);
    do_txn(0, 2'b10, 4'd5, 32'h20, s, b, d);
    checks++;
    if (s !== 1'b0 || b !== 32'hFFFF_FFF0) begin
      errors++; $display("FAIL dep_overflow succ=%b bal=%h, need 0/fffffff0", s, b);
    end
    do_txn(0, 2'b10, 4'd5, 32'h0F, s, b, d);
    checks++;
    if (s !== 1'b1 || b !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL dep_fit succ=%b bal=%h, need 1/ffffffff", s, b);
    end
    do_txn(3, 2'b01, 4'd5, 32'h0, s, b, d);
    checks++;
    if (s !== 1'b1 || b !== 32'hFFFF_FFFF || d !== 2'd3) begin
      errors++; $display("FAIL wd_zero succ=%b bal=%h id=%0d, need 1/ffffffff/3", s, b, d);
    end
    do_txn(3, 2'b10, 4'd5, 32'h0, s, b, d);
    checks++;
    if (s !== 1'b1 || b !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL dep_zero succ=%b bal=%h, need 1/ffffffff", s, b);
    end
  endtask

  task automatic test_invalid;
    logic s; logic [31:0] b; logic [1:0] d;
    do_txn(2, 2'b00, 4'd12, 32'd0, s, b, d);
    checks++;
    if (s !== 1'b0 || b !== 32'd0) begin
      errors++; $display("FAIL bad_acc succ=%b bal=%0d, need 0/0", s, b);
    end
    do_txn(2, 2'b11, 4'd3, 32'd5, s, b, d);
    checks++;
    if (s !== 1'b0 || b !== 32'd0) begin
      errors++; $display("FAIL bad_op succ=%b bal=%0d, need 0/0", s, b);
    end
    do_txn(2, 2'b00, 4'd3, 32'd0, s, b, d);
    checks++;
    if (s !== 1'b1 || b !== 32'd300) begin
      errors++; $display("FAIL bad_op_unchanged succ=%b bal=%0d, need 1/300", s, b);
    end
  endtask

  task automatic test_sample_once;
    logic s; logic [31:0] b; logic [1:0] d;
    @(negedge clk);
    set_txn(3, 2'b01, 4'd3, 32'd100);
    req[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++; $display("FAIL hold_grant gnt=%b, need 1000", gnt);
    end
    // change everything after grant; also try a preload while not IDLE
    set_txn(3, 2'b10, 4'd5, 32'd250);
    req[3] = 1'b0;
    init_we = 1'b1; init_idx = 4'd3; init_data = 32'd999;
    @(negedge clk);
    init_we = 1'b0;
    checks++;
    if (done !== 1'b1 || done_id !== 2'd3 || success !== 1'b1 || balance !== 32'd200) begin
      errors++;
      $display("FAIL hold_done done=%b id=%0d succ=%b bal=%0d, need 1/3/1/200", done, done_id, success, balance);
    end
    do_txn(0, 2'b00, 4'd3, 32'd0, s, b, d);
    checks++;
    if (s !== 1'b1 || b !== 32'd200) begin
      errors++; $display("FAIL init_ignored_busy succ=%b bal=%0d, need 1/200", s, b);
    end
  endtask

  task automatic test_init_priority;
    @(negedge clk);
    init_we = 1'b1; init_idx = 4'd4; init_data = 32'd77;
    set_txn(0, 2'b00, 4'd4, 32'd0);
    req[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL init_prio gnt=%b busy=%b, need 0000/0", gnt, busy);
    end
    init_we = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL init_then_grant gnt=%b, need 0001", gnt);
    end
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || success !== 1'b1 || balance !== 32'd77) begin
      errors++; $display("FAIL init_readback done=%b succ=%b bal=%0d, need 1/1/77", done, success, balance);
    end
  endtask

  task automatic test_round_robin;
    int n, cyc, last_cyc;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_txn(i, 2'b00, 4'd0, 32'd0);
    req = 4'b1111;
    n = 0; cyc = 0; last_cyc = 0;
    while (n < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        checks++;
        if (done_id !== 2'(n % 4) || gnt !== (4'b0001 << (n % 4))) begin
          errors++; $display("FAIL rr_order #%0d id=%0d gnt=%b, need id %0d", n, done_id, gnt, n % 4);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++; $display("FAIL rr_spacing #%0d gap=%0d, need 3", n, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        n++;
      end
    end
    req = '0;
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL rr_count saw %0d dones, need 5", n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int stray;
    preload(4'd7, 32'd100);
    @(negedge clk);
    set_txn(2, 2'b10, 4'd7, 32'd50);
    req[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || gnt !== 4'b0100) begin
      errors++; $display("FAIL rst_mid_exec busy=%b gnt=%b, need 1/0100", busy, gnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async gnt=%b busy=%b done=%b, need 0000/0/0", gnt, busy, done);
    end
    req[2] = 1'b0;
    @(negedge clk); rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL rst_mid_no_done saw %0d done cycles, need 0", stray);
    end
    for (int i = 0; i < NUM_REQ; i++) set_txn(i, 2'b00, 4'd7, 32'd0);
    req = 4'b1111;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL rst_mid_ptr gnt=%b, need 0001", gnt);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || done_id !== 2'd0 || success !== 1'b1 || balance !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_cleared done=%b id=%0d succ=%b bal=%0d, need 1/0/1/0", done, done_id, success, balance);
    end
  endtask

  initial begin
    test_reset;
    test_withdraw;
    test_insufficient;
    test_deposit_overflow;
    test_invalid;
    test_sample_once;
    test_init_priority;
    test_round_robin;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
